button_press_classifier: RTL and testbench

- Sits directly downstream of the button debouncer. Consumes its debounced level and one-cycle p_edge/n_edge pulses.
- Classifies each gesture as short press, double press or long press, and emits one-cycle event pulses for the UI/control logic.
- All timing is in clk cycles. The system clock is 100 MHz, so the defaults give 1 s long-press and 300 ms double-click windows.

---
 rtl/button_press_classifier_if.sv | 25 ++
 rtl/button_press_classifier.sv | 141 ++++++++++++++
 tb/tb_button_press_classifier.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/button_press_classifier_if.sv
// Gesture interface between the debouncer-side driver and the classifier.
// master drives the debounced level and edges; slave returns event pulses.
interface button_press_classifier_if;
   logic debounced;
   logic p_edge;
   logic n_edge;
   logic short_press;
   logic double_press;
   logic long_press;
   logic hold;
   logic repeat_pulse;
   logic busy;

   modport master (
      output debounced, p_edge, n_edge,
      input  short_press, double_press, long_press,
      input  hold, repeat_pulse, busy
   );

   modport slave (
      input  debounced, p_edge, n_edge,
      output short_press, double_press, long_press,
      output hold, repeat_pulse, busy
   );
endinterface

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short, double and long presses.
// Define BUTTON_AUTOREPEAT_EN to add auto-repeat pulses while long-held.
module button_press_classifier #(
   parameter int LONG_CYCLES   = 100_000_000,
   parameter int DCLICK_CYCLES = 30_000_000,
   parameter int REPEAT_CYCLES = 20_000_000,
   parameter int CNT_W         = 27
) (
   input logic clk,
   input logic reset,
   button_press_classifier_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS1,
      WAIT2,
      PRESS2,
      LONG_HELD
   } state_t;

   localparam logic [CNT_W-1:0] T_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

   if (LONG_CYCLES < 2 || DCLICK_CYCLES < 2 || REPEAT_CYCLES < 1 ||
       ((longint'(LONG_CYCLES) - 1) >> CNT_W) != 0 ||
       ((longint'(DCLICK_CYCLES) - 1) >> CNT_W) != 0 ||
       ((longint'(REPEAT_CYCLES) - 1) >> CNT_W) != 0) begin : g_bad_params
      $error("button_press_classifier: illegal timing parameters");
   end

   state_t state;
   logic [CNT_W-1:0] timer;
   logic pe;
   logic ne;

   // Simultaneous press and release edges cancel each other out.
   assign pe = bus.p_edge & ~bus.n_edge;
   assign ne = bus.n_edge & ~bus.p_edge;

   // Gesture FSM. The timer counts cycles elapsed since the entry event,
   // so it reads 1 in the first cycle of PRESS1/WAIT2 and the timeout
   // pulse lands exactly LIMIT cycles after the deciding edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         timer            <= '0;
         bus.short_press  <= 1'b0;
         bus.double_press <= 1'b0;
         bus.long_press   <= 1'b0;
         bus.hold         <= 1'b0;
         bus.busy         <= 1'b0;
      end else begin
         bus.short_press  <= 1'b0;
         bus.double_press <= 1'b0;
         bus.long_press   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pe) begin
                  state    <= PRESS1;
                  timer    <= T_ONE;
                  bus.busy <= 1'b1;
               end
            end
            PRESS1: begin
               if (ne) begin
                  state <= WAIT2;
                  timer <= T_ONE;
               end else if (timer == LONG_LAST && bus.debounced) begin
                  state          <= LONG_HELD;
                  timer          <= '0;
                  bus.long_press <= 1'b1;
                  bus.hold       <= 1'b1;
               end else begin
                  timer <= timer + T_ONE;
               end
            end
            WAIT2: begin
               if (pe) begin
                  state            <= PRESS2;
                  timer            <= '0;
                  bus.double_press <= 1'b1;
               end else if (timer == DCLICK_LAST) begin
                  state           <= IDLE;
                  timer           <= '0;
                  bus.short_press <= 1'b1;
                  bus.busy        <= 1'b0;
               end else begin
                  timer <= timer + T_ONE;
               end
            end
            PRESS2: begin
               if (ne) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            LONG_HELD: begin
               if (ne) begin
                  state    <= IDLE;
                  timer    <= '0;
                  bus.hold <= 1'b0;
                  bus.busy <= 1'b0;
               end else begin
                  timer <= timer + T_ONE;
               end
            end
            default: begin
               state    <= IDLE;
               timer    <= '0;
               bus.hold <= 1'b0;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef BUTTON_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] rpt_timer;

   // Repeat divider runs from the first LONG_HELD cycle until release.
   always_ff @(posedge clk) begin
      if (reset || state != LONG_HELD || ne) begin
         rpt_timer        <= '0;
         bus.repeat_pulse <= 1'b0;
      end else if (rpt_timer == RPT_LAST) begin
         rpt_timer        <= '0;
         bus.repeat_pulse <= 1'b1;
      end else begin
         rpt_timer        <= rpt_timer + T_ONE;
         bus.repeat_pulse <= 1'b0;
      end
   end
`else
   assign bus.repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier (LONG=20, DCLICK=10, REPEAT=5).
// Output vector order: short, double, long, hold, repeat, busy.
module tb_button_press_classifier;
   localparam int LONG_C   = 20;
   localparam int DCLICK_C = 10;
   localparam int REPEAT_C = 5;
   localparam int W        = 5;

   logic clk = 1'b0;
   logic reset;
   int n_checks = 0;
   int n_fails  = 0;

   button_press_classifier_if bus ();

   button_press_classifier #(
      .LONG_CYCLES  (LONG_C),
      .DCLICK_CYCLES(DCLICK_C),
      .REPEAT_CYCLES(REPEAT_C),
      .CNT_W        (W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] obs();
      return {bus.short_press, bus.double_press, bus.long_press,
              bus.hold, bus.repeat_pulse, bus.busy};
   endfunction

   task automatic drive(input logic pe, input logic ne, input logic deb);
      bus.p_edge    = pe;
      bus.n_edge    = ne;
      bus.debounced = deb;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [5:0] got;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         got = obs();
         n_checks++;
         if (got !== 6'b0) begin
            n_fails++;
            $display("FAIL reset c%0d got %b want %b", k, got, 6'b0);
         end
      end
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, k == 0, k < 3);
         tick();
         got = obs();
         n_checks++;
         if (got !== 6'b0) begin
            n_fails++;
            $display("FAIL stray_n_edge c%0d got %b want %b", k, got, 6'b0);
         end
      end
   endtask

   task automatic test_short();
      logic [5:0] got;
      logic [5:0] exp;
      for (int k = 0; k <= 20; k++) begin
         drive(k == 0, k == 5, k < 5);
         exp = {k == 15, 4'b0000, k >= 1 && k <= 14};
         got = obs();
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL short c%0d got %b want %b", k, got, exp);
         end
         tick();
      end
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_double();
      logic [5:0] got;
      logic [5:0] exp;
      for (int k = 0; k <= 25; k++) begin
         drive(k == 0 || k == 9, k == 5 || k == 12,
               k < 5 || (k >= 9 && k < 12));
         exp = {1'b0, k == 10, 3'b000, k >= 1 && k <= 12};
         got = obs();
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL double c%0d got %b want %b", k, got, exp);
         end
         tick();
      end
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_window_edge();
      logic [5:0] got;
      logic [5:0] exp;
      for (int k = 0; k <= 25; k++) begin
         drive(k == 0 || k == 14, k == 5 || k == 16,
               k < 5 || (k >= 14 && k < 16));
         exp = {1'b0, k == 15, 3'b000, k >= 1 && k <= 16};
         got = obs();
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL dclick_last c%0d got %b want %b", k, got, exp);
         end
         tick();
      end
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_long();
      logic [5:0] got;
      logic [5:0] exp;
      logic rpt;
      for (int k = 0; k <= 40; k++) begin
         drive(k == 0, k == 32, k < 32);
`ifdef BUTTON_AUTOREPEAT_EN
         rpt = (k == 25 || k == 30);
`else
         rpt = 1'b0;
`endif
         exp = {2'b00, k == 20, k >= 20 && k <= 32, rpt,
                k >= 1 && k <= 32};
         got = obs();
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL long c%0d got %b want %b", k, got, exp);
         end
         tick();
      end
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [5:0] got;
      logic [5:0] exp;
      for (int k = 0; k <= 25; k++) begin
         drive(k == 0, k == 5, k < 5);
         reset = (k == 8);
         exp = {5'b00000, k >= 1 && k <= 8};
         got = obs();
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL reset_mid c%0d got %b want %b", k, got, exp);
         end
         tick();
      end
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_both_edges();
      logic [5:0] got;
      logic [5:0] exp;
      for (int k = 0; k <= 6; k++) begin
         drive(k == 3, k == 3, 1'b0);
         got = obs();
         n_checks++;
         if (got !== 6'b0) begin
            n_fails++;
            $display("FAIL both_idle c%0d got %b want %b", k, got, 6'b0);
         end
         tick();
      end
      for (int k = 0; k <= 20; k++) begin
         drive(k == 0 || k == 2, k == 2 || k == 5, k < 5);
         exp = {k == 15, 4'b0000, k >= 1 && k <= 14};
         got = obs();
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL both_press1 c%0d got %b want %b", k, got, exp);
         end
         tick();
      end
      drive(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b1);
      test_reset();
      test_short();
      test_double();
      test_window_edge();
      test_long();
      test_reset_mid();
      test_both_edges();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end
endmodule
